// File: rtl/rr_multichannel_recorder.sv
// N-channel valid/ready recorder: per-channel FIFO passthrough plus a single
// staged log record (begin with data / end) with lossless logging back-pressure.
module rr_mcr_fifo #(
  parameter int DW    = 64,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_data,
  output logic          o_full,
  output logic          o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][DW-1:0] r_mem;
  logic [AW-1:0]            r_wptr, r_rptr;
  logic [AW:0]              r_cnt;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_data  = r_mem[r_rptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_data;
  end
endmodule

module rr_multichannel_recorder #(
  parameter int                      NUM_CHANNELS = 5,
  parameter int                      DATA_WIDTH   = 64,
  parameter int                      PIPE_DEPTH   = 4,
  parameter logic [NUM_CHANNELS-1:0] LOGB_MASK    = '1
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               record_en,
  input  logic [NUM_CHANNELS-1:0]            in_valid,
  output logic [NUM_CHANNELS-1:0]            in_ready,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] in_data,
  output logic [NUM_CHANNELS-1:0]            out_valid,
  input  logic [NUM_CHANNELS-1:0]            out_ready,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] out_data,
  output logic [NUM_CHANNELS-1:0]            logb_valid,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] logb_data,
  output logic [NUM_CHANNELS-1:0]            loge_valid,
  input  logic                               log_ready,
  output logic [31:0]                        pkt_cnt
);
  logic                                r_rec_q;
  logic                                r_alive;
  logic [NUM_CHANNELS-1:0]             r_logb_valid, r_loge_valid;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0]  r_logb_data;
  logic [31:0]                         r_pkt_cnt;

  logic [NUM_CHANNELS-1:0]             w_full, w_empty, w_in_fire, w_out_fire;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0]  w_logb_data_d;
  logic                                w_stage_v, w_log_ok, w_accept;

  assign w_stage_v = |r_logb_valid | |r_loge_valid;
  assign w_log_ok  = !r_rec_q || !w_stage_v || log_ready;
  assign w_accept  = w_stage_v && log_ready;

  // r_alive holds the upstream handshake low while reset is asserted.
  assign in_ready   = ~w_full  & {NUM_CHANNELS{w_log_ok && r_alive}};
  assign out_valid  = ~w_empty & {NUM_CHANNELS{w_log_ok}};
  assign w_in_fire  = in_valid  & in_ready;
  assign w_out_fire = out_valid & out_ready;

  genvar g;
  generate
    for (g = 0; g < NUM_CHANNELS; g++) begin : g_ch
      rr_mcr_fifo #(.DW(DATA_WIDTH), .DEPTH(PIPE_DEPTH)) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_in_fire[g]),
        .i_data  (in_data[g*DATA_WIDTH +: DATA_WIDTH]),
        .i_pop   (w_out_fire[g]),
        .o_data  (out_data[g*DATA_WIDTH +: DATA_WIDTH]),
        .o_full  (w_full[g]),
        .o_empty (w_empty[g])
      );
      assign w_logb_data_d[g*DATA_WIDTH +: DATA_WIDTH] =
        (w_in_fire[g] && LOGB_MASK[g]) ? in_data[g*DATA_WIDTH +: DATA_WIDTH] : '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rec_q      <= 1'b0;
      r_alive      <= 1'b0;
      r_logb_valid <= '0;
      r_loge_valid <= '0;
      r_logb_data  <= '0;
      r_pkt_cnt    <= '0;
    end else begin
      r_rec_q <= record_en;
      r_alive <= 1'b1;
      if (r_rec_q && w_log_ok) begin
        r_logb_valid <= w_in_fire & LOGB_MASK;
        r_loge_valid <= w_out_fire;
        r_logb_data  <= w_logb_data_d;
      end else if (!r_rec_q && w_accept) begin
        r_logb_valid <= '0;
        r_loge_valid <= '0;
        r_logb_data  <= '0;
      end
      if (w_accept && r_pkt_cnt != 32'hFFFF_FFFF) r_pkt_cnt <= r_pkt_cnt + 32'd1;
    end
  end

  assign logb_valid = r_logb_valid;
  assign loge_valid = r_loge_valid;
  assign logb_data  = r_logb_data;
  assign pkt_cnt    = r_pkt_cnt;
endmodule

// File: tb/tb_rr_multichannel_recorder.sv
// Directed bench for rr_multichannel_recorder (5 channels, mask 5'b00111).
module tb_rr_multichannel_recorder;
  localparam int NC = 5;
  localparam int DW = 64;

  logic              clk = 1'b0;
  logic              rstn = 1'b1;
  logic              record_en = 1'b0;
  logic [NC-1:0]     in_valid = '0, in_ready, out_valid, out_ready = '0;
  logic [NC*DW-1:0]  in_data = '0, out_data, logb_data;
  logic [NC-1:0]     logb_valid, loge_valid;
  logic              log_ready = 1'b0;
  logic [31:0]       pkt_cnt;

  int n_chk = 0;
  int n_fail = 0;

  rr_multichannel_recorder #(
    .NUM_CHANNELS(NC), .DATA_WIDTH(DW), .PIPE_DEPTH(4), .LOGB_MASK(5'b00111)
  ) dut (
    .clk(clk), .rstn(rstn), .record_en(record_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .logb_valid(logb_valid), .logb_data(logb_data), .loge_valid(loge_valid),
    .log_ready(log_ready), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int ch, input logic [63:0] d);
    in_data[ch*DW +: DW] = d;
  endtask

  initial begin
    // reset
    #1 rstn = 1'b0;
    #2;
    chk("rst_in_ready", 64'(in_ready), 0);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_logb_valid", 64'(logb_valid), 0);
    chk("rst_loge_valid", 64'(loge_valid), 0);
    chk("rst_logb_data", 64'(|logb_data), 0);
    chk("rst_pkt_cnt", 64'(pkt_cnt), 0);
    step(); step();
    rstn = 1'b1;
    record_en = 1'b1; log_ready = 1'b1; out_ready = '1;
    step(); step();

    // passthrough ch0
    in_valid = 5'b00001; set_in(0, 64'hA5);
    #1 chk("pt_in_ready0", 64'(in_ready[0]), 1);
    step();
    in_valid = '0;
    #1;
    chk("pt_out_valid", 64'(out_valid), 64'b00001);
    chk("pt_out_data", out_data[0 +: DW], 64'hA5);
    chk("pt_logb_valid", 64'(logb_valid), 64'b00001);
    chk("pt_logb_data", logb_data[0 +: DW], 64'hA5);
    step();
    chk("pt_loge_valid", 64'(loge_valid), 64'b00001);
    chk("pt_logb_clear", 64'(logb_valid), 0);
    chk("pt_pkt1", 64'(pkt_cnt), 1);
    step();
    chk("pt_pkt2", 64'(pkt_cnt), 2);
    chk("pt_stage_empty", 64'(logb_valid | loge_valid), 0);

    // back-pressure with a staged begin record on ch1
    out_ready = '0;
    in_valid = 5'b00010; set_in(1, 64'h11);
    step();
    in_valid = '0; log_ready = 1'b0;
    #1;
    chk("bp_in_ready", 64'(in_ready), 0);
    chk("bp_out_valid", 64'(out_valid), 0);
    in_valid = 5'b00100; set_in(2, 64'h99); out_ready = '1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("bp_stage_hold", 64'(logb_valid), 64'b00010);
      chk("bp_data_hold", logb_data[DW +: DW], 64'h11);
    end
    chk("bp_pkt_hold", 64'(pkt_cnt), 2);
    chk("bp_out_valid_hold", 64'(out_valid), 0);
    in_valid = '0; out_ready = '0; log_ready = 1'b1;
    step();
    chk("bp_pkt_accept", 64'(pkt_cnt), 3);
    chk("bp_stage_clear", 64'(logb_valid | loge_valid), 0);
    step();
    chk("bp_no_dup", 64'(pkt_cnt), 3);
    chk("bp_resume", 64'(out_valid), 64'b00010);
    chk("bp_head", out_data[DW +: DW], 64'h11);
    out_ready = 5'b00010;
    step();
    out_ready = '0;
    chk("bp_pop_loge", 64'(loge_valid), 64'b00010);
    step();
    chk("bp_pkt4", 64'(pkt_cnt), 4);

    // full FIFO on ch2
    in_valid = 5'b00100;
    for (int k = 0; k < 5; k++) begin
      set_in(2, 64'h20 + 64'(k));
      #1 chk("full_in_ready", 64'(in_ready[2]), (k < 4) ? 64'd1 : 64'd0);
      step();
    end
    in_valid = '0;
    step();
    chk("full_pkt8", 64'(pkt_cnt), 8);
    out_ready = 5'b00100;
    for (int k = 0; k < 4; k++) begin
      #1 chk("full_out_data", out_data[2*DW +: DW], 64'h20 + 64'(k));
      step();
      chk("full_loge", 64'(loge_valid), 64'b00100);
    end
    out_ready = '0;
    #1 chk("full_drained", 64'(out_valid[2]), 0);
    step();
    chk("full_pkt12", 64'(pkt_cnt), 12);

    // masked channel 4
    in_valid = 5'b10000; set_in(4, 64'h44);
    step();
    in_valid = '0;
    chk("mask_logb_valid", 64'(logb_valid), 0);
    chk("mask_logb_data", logb_data[4*DW +: DW], 0);
    out_ready = 5'b10000;
    #1 chk("mask_out_data", out_data[4*DW +: DW], 64'h44);
    step();
    out_ready = '0;
    chk("mask_loge", 64'(loge_valid), 64'b10000);
    chk("mask_logb_never", 64'(logb_valid), 0);
    step();
    chk("mask_pkt13", 64'(pkt_cnt), 13);

    // simultaneous begin ch0 + end ch1
    in_valid = 5'b00010; set_in(1, 64'h55);
    step();
    in_valid = 5'b00001; set_in(0, 64'h66); out_ready = 5'b00010;
    step();
    in_valid = '0; out_ready = '0;
    chk("sim_logb", 64'(logb_valid), 64'b00001);
    chk("sim_loge", 64'(loge_valid), 64'b00010);
    chk("sim_data", logb_data[0 +: DW], 64'h66);
    chk("sim_pkt14", 64'(pkt_cnt), 14);
    step();
    chk("sim_pkt15", 64'(pkt_cnt), 15);

    // record disabled: traffic passes, no records even with log_ready low
    record_en = 1'b0;
    step(); step();
    log_ready = 1'b0; out_ready = '1;
    in_valid = 5'b01000; set_in(3, 64'h33);
    #1 chk("off_in_ready", 64'(in_ready[3]), 1);
    step();
    chk("off_out_valid", 64'(out_valid), 64'b01000);
    chk("off_no_records", 64'(logb_valid | loge_valid), 0);
    step();
    chk("off_pkt", 64'(pkt_cnt), 15);

    // reset mid-burst
    #2 rstn = 1'b0;
    #1;
    chk("mrst_in_ready", 64'(in_ready), 0);
    chk("mrst_out_valid", 64'(out_valid), 0);
    chk("mrst_logs", 64'(logb_valid | loge_valid), 0);
    chk("mrst_pkt", 64'(pkt_cnt), 0);
    in_valid = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rr_multichannel_recorder.md
Name: rr_multichannel_recorder

Overview:
- Parametrised, N-channel generalisation of the per-channel valid/ready logger used by the AXI recorders.
- Sits between the shell side (in_*) and the CL side (out_*) of any group of valid/ready channels.
- Buffers each channel in a PIPE_DEPTH FIFO and emits begin records (with data) and end records to the logging bus.
- Adds a per-channel begin-logging mask, a runtime record enable, lossless back-pressure from the logging bus, and a saturating packet counter.

Parameters:
- NUM_CHANNELS, 5: number of valid/ready channels.
- DATA_WIDTH, 64: payload width per channel. Uniform; narrower channels zero-extend.
- PIPE_DEPTH, 4: FIFO entries per channel. Power of two, ≥2.
- LOGB_MASK, all ones: bit i=1 means channel i emits begin records with data. Bit i=0 means end records only.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- record_en  in  1  runtime logging enable, registered internally.
- in_valid  in  NUM_CHANNELS  upstream valid.
- in_ready  out  NUM_CHANNELS  upstream ready.
- in_data  in  NUM_CHANNELS*DATA_WIDTH  channel i at [i*DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  NUM_CHANNELS  downstream valid.
- out_ready  in  NUM_CHANNELS  downstream ready.
- out_data  out  NUM_CHANNELS*DATA_WIDTH  FIFO head data, packed as in_data.
- logb_valid  out  NUM_CHANNELS  begin record present, registered.
- logb_data  out  NUM_CHANNELS*DATA_WIDTH  begin payload, registered.
- loge_valid  out  NUM_CHANNELS  end record present, registered.
- log_ready  in  1  logging bus accepts the staged record.
- pkt_cnt  out  32  count of accepted log records, saturates at 2^32-1.

Behaviour:
- Reset (async assert, sync release): all FIFOs empty, stage cleared, rec_q=0, pkt_cnt=0. Outputs in_ready=0, out_valid=0, logb_valid=0, loge_valid=0, logb_data=0.
- Definitions:
  - rec_q = record_en delayed one cycle.
  - stage_v = |logb_valid | |loge_valid.
  - log_ok = !rec_q || !stage_v || log_ready.
  - in_fire[i] = in_valid & in_ready; out_fire[i] = out_valid & out_ready.
- Handshake gating:
  - in_ready[i] = !full[i] && log_ok.
  - out_valid[i] = !empty[i] && log_ok.
  - out_data[i] = FIFO head.
  - in_ready must not depend on in_valid.
- FIFO rules:
  - Simultaneous push and pop when full: the push is refused (in_ready=0 when full).
  - Simultaneous push and pop when empty: the entry is not visible until the next cycle, so minimum in-to-out latency is 1 cycle.
  - Pointers wrap modulo PIPE_DEPTH. Occupancy counter is clog2(PIPE_DEPTH)+1 bits.
- Log stage (single register):
  - When rec_q && log_ok, the stage loads every cycle:
    - logb_valid[i] = in_fire[i] & LOGB_MASK[i]; logb_data slice i = in_data slice i when that bit is set, else 0.
    - loge_valid[i] = out_fire[i].
  - When rec_q && !log_ok, the stage holds and no channel fires, so no event is ever lost or duplicated.
  - When !rec_q: nothing new is loaded. A pending stage still drains on log_ready, then clears.
  - A record is accepted when stage_v && log_ready; pkt_cnt then increments by 1 and saturates.
- record_en toggle:
  - Takes effect one cycle later.
  - A handshake in the cycle rec_q first rises is logged.
  - Deassertion never drops an already-staged record.
- Same-cycle events: begin and end on the same channel, or on several channels, share one staged record.
- Reset mid-operation: FIFO contents and the staged record are discarded.

Test Plan:
- Passthrough, record_en=1, log_ready=1, ch0 single beat data=0xA5 accepted at cycle t with out_ready=1 → out_valid[0] at t+1. logb_valid[0]=1 with data 0xA5 at t+1. loge_valid[0]=1 at t+2. pkt_cnt=2.
- Back-pressure: hold log_ready=0 with a staged record → in_ready and out_valid all 0, stage stable for 10 cycles. log_ready=1 → one record accepted, traffic resumes, no duplicate.
- Full FIFO: PIPE_DEPTH=4, out_ready=0, push 5 beats → in_ready[i]=0 after 4. Pop with out_ready=1 → beats emerge in order, with 4 loge records.
- Mask: LOGB_MASK=5'b00111, beat on ch4 → logb_valid[4] never 1, loge_valid[4]=1 on out handshake.
- Simultaneous: ch0 in_fire and ch1 out_fire in the same cycle → one stage record with logb_valid=00001 and loge_valid=00010. pkt_cnt +1.
- Mode/reset: record_en=0 → traffic passes with log_ready=0 and no log records. Assert rstn low mid-burst → all outputs 0 immediately, pkt_cnt=0.
